// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: single-lane parking gate controller.
// Handles entrance sensing and two-digit password entry, with a password
// timeout, tailgating stop, an occupancy counter with a FULL capacity limit,
// and Moore-decoded status LEDs and active-low 7-segment digits.
// Optional feature macro: PARK_LOCKOUT_EN. When it is defined, MAX_TRIES
// consecutive wrong passwords enter LOCKOUT for LOCK_CYCLES cycles.
module parking_gate_ctrl #(
  parameter int                  PW_WIDTH       = 2,
  parameter logic [PW_WIDTH-1:0] PASSWORD_1     = 2'b01,
  parameter logic [PW_WIDTH-1:0] PASSWORD_2     = 2'b10,
  parameter int                  CAPACITY       = 8,
  parameter int                  TIMEOUT_CYCLES = 16,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCK_CYCLES    = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sensor_entrance,
  input  logic                             sensor_exit,
  input  logic                             car_departed,
  input  logic [PW_WIDTH-1:0]              password_1,
  input  logic [PW_WIDTH-1:0]              password_2,
  input  logic                             pw_valid,
  output logic                             GREEN_LED,
  output logic                             RED_LED,
  output logic [6:0]                       HEX_1,
  output logic [6:0]                       HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
  output logic                             full
);

  localparam int OCC_W = $clog2(CAPACITY + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
`ifdef PARK_LOCKOUT_EN
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
`endif

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_G     = 7'h42;
  localparam logic [6:0] GLYPH_O     = 7'h40;
  localparam logic [6:0] GLYPH_S     = 7'h12;
  localparam logic [6:0] GLYPH_P     = 7'h0C;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_U     = 7'h41;
`ifdef PARK_LOCKOUT_EN
  localparam logic [6:0] GLYPH_L     = 7'h47;
  localparam logic [6:0] GLYPH_C     = 7'h46;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASSWORD,
    WRONG_PASS,
    RIGHT_PASS,
    STOP,
    FULL
`ifdef PARK_LOCKOUT_EN
    , LOCKOUT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
`ifdef PARK_LOCKOUT_EN
  logic [LCK_W-1:0]   lock_q, lock_d;
`endif
  logic               green_q, green_d;
  logic               red_q, red_d;
  logic [6:0]         hex1_q, hex1_d;
  logic [6:0]         hex2_q, hex2_d;

  logic               match;
  logic               occ_inc;
  logic               occ_dec;

  assign match     = pw_valid && (password_1 == PASSWORD_1) && (password_2 == PASSWORD_2);
  assign full      = (occ_q == OCC_W'(CAPACITY));
  assign occupancy = occ_q;
  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;

  // Next-state, timers and tries; occ_inc flags a car passing the open gate
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tries_d = tries_q;
    occ_inc = 1'b0;
`ifdef PARK_LOCKOUT_EN
    lock_d  = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (full) begin
          state_d = FULL;
        end else if (sensor_entrance) begin
          state_d = WAIT_PASSWORD;
          timer_d = '0;
        end
      end
      WAIT_PASSWORD, WRONG_PASS: begin
        if (match) begin
          state_d = RIGHT_PASS;
          tries_d = '0;
        end else if (pw_valid) begin
          // tries keeps counting with lockout disabled; it simply has no effect
          tries_d = tries_q + 1'b1;
          timer_d = '0;
          state_d = WRONG_PASS;
`ifdef PARK_LOCKOUT_EN
          if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            state_d = LOCKOUT;
            lock_d  = '0;
          end
`endif
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          tries_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RIGHT_PASS: begin
        if (sensor_exit) begin
          occ_inc = 1'b1;
          state_d = sensor_entrance ? STOP : IDLE;
        end
      end
      STOP: begin
        if (full) begin
          state_d = FULL;
        end else if (match) begin
          state_d = RIGHT_PASS;
        end
      end
      FULL: begin
        if (!full) begin
          state_d = IDLE;
        end
      end
`ifdef PARK_LOCKOUT_EN
      LOCKOUT: begin
        if (lock_q == LCK_W'(LOCK_CYCLES - 1)) begin
          state_d = IDLE;
          tries_d = '0;
          timer_d = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Occupancy: simultaneous arrival and departure leave the count unchanged
  always_comb begin
    occ_d   = occ_q;
    occ_dec = car_departed && (occ_q != '0);
    if (occ_inc && !occ_dec && (occ_q != OCC_W'(CAPACITY))) begin
      occ_d = occ_q + 1'b1;
    end else if (occ_dec && !occ_inc) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Moore decode of the upcoming state so the outputs register with it
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    hex1_d  = GLYPH_BLANK;
    hex2_d  = GLYPH_BLANK;
    unique case (state_d)
      WRONG_PASS: begin red_d = 1'b1;   hex1_d = GLYPH_E; hex2_d = GLYPH_E; end
      RIGHT_PASS: begin green_d = 1'b1; hex1_d = GLYPH_G; hex2_d = GLYPH_O; end
      STOP:       begin red_d = 1'b1;   hex1_d = GLYPH_S; hex2_d = GLYPH_P; end
      FULL:       begin red_d = 1'b1;   hex1_d = GLYPH_F; hex2_d = GLYPH_U; end
`ifdef PARK_LOCKOUT_EN
      LOCKOUT:    begin red_d = 1'b1;   hex1_d = GLYPH_L; hex2_d = GLYPH_C; end
`endif
      default:    begin end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      tries_q <= '0;
      occ_q   <= '0;
`ifdef PARK_LOCKOUT_EN
      lock_q  <= '0;
`endif
      green_q <= 1'b0;
      red_q   <= 1'b0;
      hex1_q  <= GLYPH_BLANK;
      hex2_q  <= GLYPH_BLANK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
      occ_q   <= occ_d;
`ifdef PARK_LOCKOUT_EN
      lock_q  <= lock_d;
`endif
      green_q <= green_d;
      red_q   <= red_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: scoreboard bench for parking_gate_ctrl (CAPACITY=4).
// The stimulus process applies one directed vector per cycle and queues the
// hand-computed state/occupancy expected after the next edge; a monitor pops
// and compares after every clock edge and after an asynchronous reset edge.
module tb_parking_gate_ctrl;

  localparam int CAP = 4;
  localparam int OW  = $clog2(CAP + 1);
  localparam logic [1:0] OK1  = 2'b01;
  localparam logic [1:0] OK2  = 2'b10;
  localparam logic [1:0] BAD1 = 2'b10;
  localparam logic [1:0] BAD2 = 2'b01;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sensor_entrance = 1'b0;
  logic          sensor_exit = 1'b0;
  logic          car_departed = 1'b0;
  logic          pw_valid = 1'b0;
  logic [1:0]    password_1 = 2'b00;
  logic [1:0]    password_2 = 2'b00;
  logic          GREEN_LED, RED_LED, full;
  logic [6:0]    HEX_1, HEX_2;
  logic [OW-1:0] occupancy;

  parking_gate_ctrl #(
    .PW_WIDTH(2), .PASSWORD_1(2'b01), .PASSWORD_2(2'b10), .CAPACITY(CAP),
    .TIMEOUT_CYCLES(16), .MAX_TRIES(3), .LOCK_CYCLES(32)
  ) dut (
    .clk(clk), .reset(reset),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .car_departed(car_departed),
    .password_1(password_1), .password_2(password_2), .pw_valid(pw_valid),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .HEX_1(HEX_1), .HEX_2(HEX_2),
    .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  typedef enum int {E_IDLE, E_WAIT, E_WRONG, E_RIGHT, E_STOP, E_FULL, E_LOCK} st_e;

  typedef struct packed {
    logic          g;
    logic          r;
    logic [6:0]    h1;
    logic [6:0]    h2;
    logic [OW-1:0] occ;
    logic          f;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Expected outputs for a state, from the state output table
  function automatic exp_t mk(st_e s, int occ);
    exp_t m;
    m.g   = 1'b0;
    m.r   = 1'b0;
    m.h1  = 7'h7F;
    m.h2  = 7'h7F;
    m.occ = OW'(occ);
    m.f   = (occ == CAP);
    case (s)
      E_WRONG: begin m.r = 1'b1; m.h1 = 7'h06; m.h2 = 7'h06; end
      E_RIGHT: begin m.g = 1'b1; m.h1 = 7'h42; m.h2 = 7'h40; end
      E_STOP:  begin m.r = 1'b1; m.h1 = 7'h12; m.h2 = 7'h0C; end
      E_FULL:  begin m.r = 1'b1; m.h1 = 7'h0E; m.h2 = 7'h41; end
      E_LOCK:  begin m.r = 1'b1; m.h1 = 7'h47; m.h2 = 7'h46; end
      default: begin end
    endcase
    return m;
  endfunction

  // Apply one vector at the falling edge and queue the post-edge expectation
  task automatic step(input logic r, input logic e, input logic x, input logic d,
                      input logic v, input logic [1:0] a, input logic [1:0] b,
                      input st_e st, input int occ, input string nm);
    @(negedge clk);
    reset           = r;
    sensor_entrance = e;
    sensor_exit     = x;
    car_departed    = d;
    pw_valid        = v;
    password_1      = a;
    password_2      = b;
    exp_q.push_back(mk(st, occ));
    name_q.push_back(nm);
  endtask

  // Monitor: compare after each clock edge or asynchronous reset assertion
  initial begin
    exp_t  cur;
    exp_t  got;
    string nm;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = '{GREEN_LED, RED_LED, HEX_1, HEX_2, occupancy, full};
        n_vec++;
        if (got !== cur) begin
          n_bad++;
          $display("FAIL %s: got g=%b r=%b hex=%h/%h occ=%0d full=%b, want g=%b r=%b hex=%h/%h occ=%0d full=%b",
                   nm, got.g, got.r, got.h1, got.h2, got.occ, got.f,
                   cur.g, cur.r, cur.h1, cur.h2, cur.occ, cur.f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and basic admission
    step(1, 0, 0, 0, 0, 0, 0, E_IDLE, 0, "reset");
    step(0, 0, 0, 0, 0, 0, 0, E_IDLE, 0, "idle");
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 0, "enter");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 0, "pw_ok");
    step(0, 0, 0, 0, 0, 0, 0, E_RIGHT, 0, "right_hold");
    step(0, 0, 1, 0, 0, 0, 0, E_IDLE, 1, "exit");
    // Tailgating stop
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 1, "enter2");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 1, "pw_ok2");
    step(0, 1, 1, 0, 0, 0, 0, E_STOP, 2, "tailgate");
    step(0, 0, 0, 0, 1, BAD1, BAD2, E_STOP, 2, "stop_bad");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 2, "stop_ok");
    step(0, 0, 1, 0, 0, 0, 0, E_IDLE, 3, "exit3");
    // Wrong then right password; exit and departure together
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 3, "enter3");
    step(0, 0, 0, 0, 1, BAD1, BAD2, E_WRONG, 3, "pw_bad");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 3, "wrong_ok");
    step(0, 0, 1, 1, 0, 0, 0, E_IDLE, 3, "exit_and_depart");
    // Password timeout: 16 cycles in WAIT_PASSWORD, then IDLE
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 3, "enter4");
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0, 0, E_WAIT, 3, "wait_timer");
    step(0, 0, 0, 0, 0, 0, 0, E_IDLE, 3, "timeout");
    // Fill to capacity
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 3, "enter5");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 3, "pw_ok5");
    step(0, 0, 1, 0, 0, 0, 0, E_IDLE, 4, "exit_full");
    step(0, 1, 0, 0, 1, OK1, OK2, E_FULL, 4, "goto_full");
    step(0, 1, 0, 0, 1, OK1, OK2, E_FULL, 4, "full_ignore");
    step(0, 0, 0, 1, 0, 0, 0, E_FULL, 3, "full_depart");
    step(0, 0, 0, 0, 0, 0, 0, E_IDLE, 3, "full_release");
    // Asynchronous reset while in RIGHT_PASS with occupancy 3
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 3, "enter6");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 3, "right_occ3");
    @(negedge clk);
    pw_valid = 1'b0;
    #2;
    exp_q.push_back(mk(E_IDLE, 0));
    name_q.push_back("async_reset");
    reset = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, E_IDLE, 0, "reset_hold");
    step(0, 0, 0, 0, 0, 0, 0, E_IDLE, 0, "reset_release");
    step(0, 0, 0, 1, 0, 0, 0, E_IDLE, 0, "depart_at_zero");
    // Park one car, then three consecutive wrong passwords
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 0, "enter7");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 0, "pw_ok7");
    step(0, 0, 1, 0, 0, 0, 0, E_IDLE, 1, "exit7");
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 1, "enter8");
    step(0, 0, 0, 0, 1, BAD1, BAD2, E_WRONG, 1, "try1");
    step(0, 0, 0, 0, 1, BAD1, BAD2, E_WRONG, 1, "try2");
`ifdef PARK_LOCKOUT_EN
    step(0, 0, 0, 0, 1, BAD1, BAD2, E_LOCK, 1, "try3_lock");
    for (int i = 0; i < 31; i++) begin
      if (i == 0)      step(0, 1, 0, 0, 1, OK1, OK2, E_LOCK, 1, "lock_ignore_pw");
      else if (i == 1) step(0, 0, 0, 1, 0, 0, 0, E_LOCK, 0, "lock_depart");
      else if (i == 2) step(0, 1, 1, 0, 0, 0, 0, E_LOCK, 0, "lock_ignore_sens");
      else             step(0, 0, 0, 0, 0, 0, 0, E_LOCK, 0, "lock_hold");
    end
    step(0, 0, 0, 0, 0, 0, 0, E_IDLE, 0, "lock_release");
    step(0, 1, 0, 0, 0, 0, 0, E_WAIT, 0, "enter9");
    step(0, 0, 0, 0, 1, BAD1, BAD2, E_WRONG, 0, "tries_cleared");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 0, "pw_ok9");
    step(0, 0, 1, 0, 0, 0, 0, E_IDLE, 1, "exit9");
`else
    step(0, 0, 0, 0, 1, BAD1, BAD2, E_WRONG, 1, "try3_nolock");
    step(0, 0, 0, 0, 1, OK1, OK2, E_RIGHT, 1, "pw_ok9");
    step(0, 0, 1, 0, 0, 0, 0, E_IDLE, 2, "exit9");
`endif
    step(0, 0, 0, 0, 0, 0, 0, E_IDLE, (`ifdef PARK_LOCKOUT_EN 1 `else 2 `endif), "final_idle");
    // Drain the scoreboard within a bounded number of cycles
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
